// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state and shift-code definitions for the shift-and-add multiplier
// Purpose: FSM state encoding and shifter control codes used by mul_sequencer.
// Ports: none (package).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_RSH  = 2'b01;
    localparam logic [1:0] SH_LSH  = 2'b10;

endpackage

// File: rtl/mul_step_datapath.sv
// rtl/mul_step_datapath.sv - multiplicand/multiplier/accumulator registers for shift-and-add
// Purpose: holds mcand, mplier and acc; one shift-and-add iteration per step.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   load            - capture a_in (zero-extended) and b_in, clear acc
//   step            - perform one iteration (conditional add, shift both operands)
//   clear           - synchronously zero all registers
//   a_in, b_in      - operands
//   acc             - current accumulator
//   acc_sum         - acc + mcand (the value acc takes if mplier_lsb is set)
//   mplier_lsb      - current multiplier LSB
module mul_step_datapath #(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic                    clear,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic [OUTPUT_WIDTH-1:0] acc,
    output logic [OUTPUT_WIDTH-1:0] acc_sum,
    output logic                    mplier_lsb
);

    logic [OUTPUT_WIDTH-1:0] mcand;
    logic [INPUT_WIDTH-1:0]  mplier;

    // The product is bounded by (2^IW-1)^2, so the OUTPUT_WIDTH sum never loses a carry.
    assign acc_sum    = acc + mcand;
    assign mplier_lsb = mplier[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= OUTPUT_WIDTH'(a_in);
            mplier <= b_in;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc_sum;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - sequential shift-and-add multiplier controller
// Purpose: runs an INPUT_WIDTH-iteration multiply on start, publishes the product with a done pulse,
//          and drives load strobes and the shift code for the surrounding register file.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   start           - request, sampled only in IDLE
//   a_in, b_in      - multiplicand / multiplier
//   busy            - high in RUN and DONE
//   done            - one-cycle pulse, product newly valid
//   product         - registered result, held until next completion
//   lda, ldb        - operand load strobes (IDLE & start)
//   ldo             - output register load strobe (same as done)
//   shift_ctl       - LSH during RUN, NONE otherwise
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int INPUT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [INPUT_WIDTH-1:0]     a_in,
    input  logic [INPUT_WIDTH-1:0]     b_in,
    output logic                       busy,
    output logic                       done,
    output logic [2*INPUT_WIDTH-1:0]   product,
    output logic                       lda,
    output logic                       ldb,
    output logic                       ldo,
    output logic [1:0]                 shift_ctl
);

    localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH;
    localparam int CW           = $clog2(INPUT_WIDTH) + 1;

    state_t                  state, state_next;
    logic [CW-1:0]           count;
    logic                    last_iter;
    logic                    dp_load, dp_step, dp_clear;
    logic [OUTPUT_WIDTH-1:0] acc, acc_sum;
    logic                    mplier_lsb;

    assign last_iter = (count == CW'(INPUT_WIDTH - 1));
    assign dp_clear  = !(state inside {IDLE, RUN, DONE});

    always_comb begin
        state_next = state;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    dp_load    = 1'b1;
                end
            end
            RUN: begin
                dp_step = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (dp_load) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + CW'(1);
            end
            // Capture the final accumulator including this iteration's conditional add.
            if (state == RUN && last_iter) begin
                product <= mplier_lsb ? acc_sum : acc;
            end
        end
    end

    mul_step_datapath #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (dp_load),
        .step       (dp_step),
        .clear      (dp_clear),
        .a_in       (a_in),
        .b_in       (b_in),
        .acc        (acc),
        .acc_sum    (acc_sum),
        .mplier_lsb (mplier_lsb)
    );

    // Strobes are gated by reset so they read 0 while reset is held even if start is high.
    assign lda       = reset && (state == IDLE) && start;
    assign ldb       = lda;
    assign busy      = (state == RUN) || (state == DONE);
    assign done      = (state == DONE);
    assign ldo       = done;
    assign shift_ctl = (state == RUN) ? SH_LSH : SH_NONE;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;

    localparam int IW = 4;
    localparam int OW = 2 * IW;
    localparam int P  = IW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] a_in = '0;
    logic [IW-1:0] b_in = '0;
    logic          busy, done, lda, ldb, ldo;
    logic [OW-1:0] product;
    logic [1:0]    shift_ctl;

    int checks = 0;
    int errors = 0;
    int last_product = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.INPUT_WIDTH(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .lda       (lda),
        .ldb       (ldb),
        .ldo       (ldo),
        .shift_ctl (shift_ctl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation starting from an IDLE negedge. Operands are disturbed after the
    // start edge (to new_a/new_b), and start may be re-pulsed mid-run to confirm it is ignored.
    task automatic run_op(input int a, input int b, input int new_a, input int new_b,
                          input bit repulse);
        int n;
        int exp;
        exp = a * b;
        a_in  = IW'(a);
        b_in  = IW'(b);
        start = 1'b1;
        #1;
        check("lda_at_start", lda, 1);
        check("ldb_at_start", ldb, 1);
        check("idle_not_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = IW'(new_a);
        b_in  = IW'(new_b);
        check("busy_after_start", busy, 1);
        check("shift_lsh_in_run", shift_ctl, 2);
        n = 0;
        while (!done && n < 20) begin
            check("product_held", product, last_product);
            if (repulse && n == 1) begin
                start = 1'b1;
                a_in  = 1;
                b_in  = 1;
                #1;
                check("lda_ignored_busy", lda, 0);
            end
            tick();
            start = 1'b0;
            n++;
        end
        check("latency", n, IW);
        check("done_pulse", done, 1);
        check("ldo_pulse", ldo, 1);
        check("shift_none_done", shift_ctl, 0);
        check("product", product, exp);
        last_product = exp;
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("product_hold", product, exp);
    endtask

    initial begin
        int ph;
        int k;

        // Reset held with start high: everything reads zero.
        start = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ldo", ldo, 0);
        check("rst_product", product, 0);
        check("rst_shift", shift_ctl, 0);
        check("rst_lda", lda, 0);
        check("rst_ldb", ldb, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed operations.
        run_op(3, 5, 3, 5, 1'b0);
        run_op(15, 15, 15, 15, 1'b0);
        run_op(0, 9, 0, 9, 1'b0);
        run_op(9, 0, 9, 0, 1'b0);
        run_op(6, 7, 6, 7, 1'b1);
        run_op(2, 3, 15, 3, 1'b0);

        // Randomized operations with operands scrambled right after capture.
        for (int i = 0; i < 20; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a 13x11 run.
        a_in  = 13;
        b_in  = 11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_product", product, 0);
        check("async_rst_shift", shift_ctl, 0);
        @(negedge clk);
        reset = 1'b1;
        last_product = 0;
        @(negedge clk);
        run_op(13, 11, 13, 11, 1'b0);

        // start held high: one operation every IW+2 cycles.
        a_in  = 2;
        b_in  = 7;
        start = 1'b1;
        #1;
        check("cont_lda_first", lda, 1);
        for (int j = 0; j < 20; j++) begin
            tick();
            ph = j % P;
            check("cont_busy", busy, (ph <= IW) ? 1 : 0);
            check("cont_done", done, (ph == IW) ? 1 : 0);
            check("cont_shift", shift_ctl, (ph < IW) ? 2 : 0);
            check("cont_lda", lda, (ph == IW + 1) ? 1 : 0);
            if (ph == IW) begin
                check("cont_product", product, 14);
            end
        end
        start = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            tick();
            k++;
        end
        check("drain_idle", busy, 0);
        check("drain_product", product, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
